led_matrix_scanner: RTL and testbench

Time-multiplexed scan driver for the 16x16 red/green LED matrix. It sits directly downstream of the pattern/game logic that produces the `RedPixels`/`GrnPixels` frame. Once per frame it snapshots that frame into an internal buffer. It then lights one line (first array index) at a time, with a blanking gap between lines to prevent ghosting, and pulses `FrameStart` when each new frame is captured.

---
 rtl/led_matrix_pkg.sv | 8 +
 rtl/led_frame_buffer.sv | 30 +++
 rtl/led_matrix_scanner.sv | 85 ++++++++
 tb/tb_led_matrix_scanner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared sizes, frame type and scan states for the LED matrix scanner
package led_matrix_pkg;
    localparam int NUM_LINES  = 16;
    localparam int LINE_W     = 16;
    localparam int LINE_IDX_W = $clog2(NUM_LINES);
    typedef logic [NUM_LINES-1:0][LINE_W-1:0] frame_t;
    typedef enum logic [1:0] {LOAD, BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: holds one red/green frame snapshot and returns the words for one line
//   CLK, RST (async, active-low) | load: capture strobe | red_in/grn_in: frames from upstream
//   line: line index | red_line/grn_line: buffered words for that line
module led_frame_buffer
    import led_matrix_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  frame_t                red_in,
    input  frame_t                grn_in,
    input  logic [LINE_IDX_W-1:0] line,
    output logic [LINE_W-1:0]     red_line,
    output logic [LINE_W-1:0]     grn_line
);
    frame_t red_buf, grn_buf;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            red_buf <= '0;
            grn_buf <= '0;
        end else if (load) begin
            red_buf <= red_in;
            grn_buf <= grn_in;
        end
    end

    assign red_line = red_buf[line];
    assign grn_line = grn_buf[line];
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: time-multiplexed line scan of a 16x16 red/green LED matrix
//   CLK, RST (async, active-low) | En: scan enable, 0 holds the scan and blanks outputs
//   RedPixels/GrnPixels: frames from upstream, snapshotted once per frame
//   LineSel: active-low one-hot line select | RedDrv/GrnDrv: drive bits for the lit line
//   FrameStart: one-cycle pulse in the snapshot cycle
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              En,
    input  frame_t            RedPixels,
    input  frame_t            GrnPixels,
    output logic [LINE_W-1:0] LineSel,
    output logic [LINE_W-1:0] RedDrv,
    output logic [LINE_W-1:0] GrnDrv,
    output logic              FrameStart
);
    localparam int MAX_C = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW    = MAX_C > 1 ? $clog2(MAX_C) : 1;

    scan_state_t           state;
    logic [CW-1:0]         cnt;
    logic [LINE_IDX_W-1:0] line;
    logic [LINE_W-1:0]     red_line, grn_line;
    logic                  load, lit;

    assign load = En && state == LOAD;
    assign lit  = En && state == DRIVE;

    led_frame_buffer u_buf (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .red_in   (RedPixels),
        .grn_in   (GrnPixels),
        .line     (line),
        .red_line (red_line),
        .grn_line (grn_line)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= LOAD;
            cnt        <= '0;
            line       <= '0;
            LineSel    <= '1;
            RedDrv     <= '0;
            GrnDrv     <= '0;
            FrameStart <= 1'b0;
        end else begin
            // Outputs reflect the state being served on this edge; En=0 blanks and holds.
            FrameStart <= load;
            LineSel    <= lit ? ~(LINE_W'(1) << line) : '1;
            RedDrv     <= lit ? red_line : '0;
            GrnDrv     <= lit ? grn_line : '0;
            if (En) begin
                case (state)
                    LOAD: begin
                        state <= BLANK;
                        cnt   <= '0;
                        line  <= '0;
                    end
                    BLANK: begin
                        cnt   <= cnt == CW'(BLANK_CYCLES - 1) ? '0 : cnt + CW'(1);
                        state <= cnt == CW'(BLANK_CYCLES - 1) ? DRIVE : BLANK;
                    end
                    DRIVE: begin
                        if (cnt == CW'(DWELL_CYCLES - 1)) begin
                            cnt   <= '0;
                            line  <= line == LINE_IDX_W'(NUM_LINES - 1) ? '0 : line + LINE_IDX_W'(1);
                            state <= line == LINE_IDX_W'(NUM_LINES - 1) ? LOAD : BLANK;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed scan tests checked against a frame-position model
module tb_led_matrix_scanner;
    import led_matrix_pkg::*;

    localparam int D = 4;
    localparam int B = 2;
    localparam int P = 1 + NUM_LINES * (B + D);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    frame_t      red, grn;
    logic [15:0] line_sel, red_drv, grn_drv;
    logic        frame_start;

    led_matrix_scanner #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .En         (en),
        .RedPixels  (red),
        .GrnPixels  (grn),
        .LineSel    (line_sel),
        .RedDrv     (red_drv),
        .GrnDrv     (grn_drv),
        .FrameStart (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ncyc = 0;
    int fs_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame decides everything; snapshot taken at position 0.
    frame_t      snap_r, snap_g;
    int          t = 0;
    logic        mvalid = 1'b0;
    logic [15:0] e_sel, e_red, e_grn;
    logic        e_fs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= 0;
            mvalid <= 1'b1;
            e_sel <= 16'hFFFF;
            e_red <= 16'h0;
            e_grn <= 16'h0;
            e_fs <= 1'b0;
        end else if (!en) begin
            e_sel <= 16'hFFFF;
            e_red <= 16'h0;
            e_grn <= 16'h0;
            e_fs <= 1'b0;
        end else begin
            automatic int p = t % P;
            automatic int q = p - 1;
            automatic int ln = q / (B + D);
            automatic bit on = p != 0 && (q % (B + D)) >= B;
            if (p == 0) begin
                snap_r <= red;
                snap_g <= grn;
            end
            e_fs <= p == 0;
            e_sel <= on ? ~(16'h1 << ln) : 16'hFFFF;
            e_red <= on ? snap_r[ln] : 16'h0;
            e_grn <= on ? snap_g[ln] : 16'h0;
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (mvalid) begin
            chk("model LineSel", line_sel, e_sel);
            chk("model RedDrv", red_drv, e_red);
            chk("model GrnDrv", grn_drv, e_grn);
            chk("model FrameStart", {15'h0, frame_start}, {15'h0, e_fs});
            if (frame_start === 1'b1) fs_q.push_back(ncyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic chk_dark(input string name);
        chk({name, " LineSel"}, line_sel, 16'hFFFF);
        chk({name, " RedDrv"}, red_drv, 16'h0);
        chk({name, " GrnDrv"}, grn_drv, 16'h0);
        chk({name, " FrameStart"}, {15'h0, frame_start}, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < NUM_LINES; i++) begin
            red[i] = 16'($urandom);
            grn[i] = 16'($urandom);
        end
        #2 rst_n = 1'b0;
        #1 chk_dark("reset async");
        red = '0;
        grn = '0;
        red[0] = 16'hFFFE;
        grn[0] = 16'h8000;
        red[15] = 16'hFFFF;
        repeat (3) tick();
        rst_n = 1'b1;
        cyc = 0;
        tick();
        chk("first FrameStart", {15'h0, frame_start}, 16'h1);
        chk("first LOAD LineSel", line_sel, 16'hFFFF);
        tick();
        chk_dark("blank0");
        tick();
        chk_dark("blank1");
        for (int i = 0; i < D; i++) begin
            tick();
            chk("line0 LineSel", line_sel, 16'hFFFE);
            chk("line0 RedDrv", red_drv, 16'hFFFE);
            chk("line0 GrnDrv", grn_drv, 16'h8000);
        end
        wait_to(15);
        red[3] = 16'h1234;
        wait_to(22);
        chk("line3 frame1 LineSel", line_sel, 16'hFFF7);
        chk("line3 frame1 RedDrv", red_drv, 16'h0);
        wait_to(94);
        chk("line15 LineSel", line_sel, 16'h7FFF);
        chk("line15 RedDrv", red_drv, 16'hFFFF);
        wait_to(98);
        chk("second FrameStart", {15'h0, frame_start}, 16'h1);
        wait_to(119);
        chk("line3 frame2 RedDrv", red_drv, 16'h1234);
        wait_to(132);
        chk("line5 pre-hold LineSel", line_sel, 16'hFFDF);
        en = 1'b0;
        tick();
        chk_dark("hold first");
        wait_to(142);
        chk_dark("hold last");
        en = 1'b1;
        tick();
        chk("resume line5 a", line_sel, 16'hFFDF);
        tick();
        chk("resume line5 b", line_sel, 16'hFFDF);
        tick();
        chk_dark("after resume");
        wait_to(160);
        chk("line8 LineSel", line_sel, 16'hFEFF);
        #2 rst_n = 1'b0;
        #1 chk_dark("reset mid-drive");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("restart FrameStart", {15'h0, frame_start}, 16'h1);
        repeat (B) tick();
        tick();
        chk("restart line0 LineSel", line_sel, 16'hFFFE);
        chk("restart line0 RedDrv", red_drv, 16'hFFFE);
        repeat (4) tick();
        checks++;
        if (fs_q.size() < 2) begin
            errors++;
            $display("FAIL frame period: only %0d FrameStart pulses seen, need 2", fs_q.size());
        end else if (fs_q[1] - fs_q[0] != P) begin
            errors++;
            $display("FAIL frame period: got %0d expected %0d", fs_q[1] - fs_q[0], P);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
